// File: rtl/seq_alu_pkg.sv
// Shared types and constants for the sequential button ALU.
package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_XOR,
        OP_SLT,
        OP_SRA,
        OP_SUB
    } op_t;

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/seq_alu_btn_debounce.sv
// One button: 2-flop synchroniser, stability counter, and one-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any return to the stable level restarts the count, so short glitches never flip it.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = stable_d & ~stable_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/seq_alu.sv
// Registered button ALU: five debounced buttons select an op, result and NZCV flags drive the LEDs.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SHIFT_AMT       = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    acc_mode,
    input  logic                    btnU,
    input  logic                    btnL,
    input  logic                    btnC,
    input  logic                    btnR,
    input  logic                    btnD,
    output logic        [WIDTH-1:0] led,
    output logic              [3:0] flags,
    output logic                    result_valid
);

    logic [4:0] btn_raw;
    logic [4:0] press;

    assign btn_raw = {btnU, btnL, btnC, btnR, btnD};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_raw(btn_raw[i]),
            .press  (press[i])
        );
    end

    state_t                  state_q, state_d;
    op_t                     op_q, op_d, sel_op;
    logic signed [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
    logic signed [WIDTH-1:0] led_q, led_d;
    logic              [3:0] flags_q, flags_d;
    logic                    valid_q, valid_d;

    logic signed [WIDTH-1:0] res;
    logic          [WIDTH:0] sum_u;
    logic                    c_flag, v_flag;
    logic              [3:0] alu_flags;

    // Fixed priority U > L > C > R > D; losers in the same cycle are simply dropped.
    always_comb begin
        if (press[4])      sel_op = OP_ADD;
        else if (press[3]) sel_op = OP_XOR;
        else if (press[2]) sel_op = OP_SLT;
        else if (press[1]) sel_op = OP_SRA;
        else               sel_op = OP_SUB;
    end

    always_comb begin
        res    = '0;
        sum_u  = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (op_q)
            OP_ADD: begin
                sum_u  = {1'b0, opa_q} + {1'b0, opb_q};
                res    = sum_u[WIDTH-1:0];
                c_flag = sum_u[WIDTH];
                v_flag = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (res[WIDTH-1] != opa_q[WIDTH-1]);
            end
            OP_XOR: res = opa_q ^ opb_q;
            OP_SLT: res = (opa_q < opb_q) ? WIDTH'(1) : '0;
            OP_SRA: res = opb_q >>> SHIFT_AMT;
            OP_SUB: begin
                res    = opa_q - opb_q;
                c_flag = $unsigned(opa_q) < $unsigned(opb_q);
                v_flag = (opa_q[WIDTH-1] != opb_q[WIDTH-1]) && (res[WIDTH-1] != opa_q[WIDTH-1]);
            end
            default: res = '0;
        endcase
        alu_flags         = '0;
        alu_flags[FLAG_N] = res[WIDTH-1];
        alu_flags[FLAG_Z] = (res == '0);
        alu_flags[FLAG_C] = c_flag;
        alu_flags[FLAG_V] = v_flag;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        led_d   = led_q;
        flags_d = flags_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|press) begin
                    op_d    = sel_op;
                    opa_d   = acc_mode ? led_q : a;
                    opb_d   = b;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                led_d   = res;
                flags_d = alu_flags;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            opa_q   <= '0;
            opb_q   <= '0;
            led_q   <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            led_q   <= led_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end

    assign led          = led_q;
    assign flags        = flags_q;
    assign result_valid = valid_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed scoreboard bench for seq_alu with WIDTH=8, DEBOUNCE_CYCLES=4, SHIFT_AMT=2.
module tb_seq_alu;

    typedef struct packed {
        logic [7:0] led;
        logic [3:0] flags;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] a, b;
    logic       acc_mode;
    logic [4:0] btns;
    logic [7:0] led;
    logic [3:0] flags;
    logic       result_valid;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    logic prev_v = 1'b0;

    seq_alu #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .SHIFT_AMT(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .b           (b),
        .acc_mode    (acc_mode),
        .btnU        (btns[4]),
        .btnL        (btns[3]),
        .btnC        (btns[2]),
        .btnR        (btns[1]),
        .btnD        (btns[0]),
        .led         (led),
        .flags       (flags),
        .result_valid(result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: every result_valid pops one expectation; extra or doubled pulses are errors.
    always @(negedge clk) begin
        if (result_valid) begin
            exp_t e;
            total++;
            assert (prev_v == 1'b0) else begin
                bad++;
                $error("FAIL valid_width got=2+cycles want=1cycle");
            end
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_valid got=led:%h flags:%b want=no_result", led, flags);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                assert ({led, flags} === e) else begin
                    bad++;
                    $error("FAIL result got=led:%h flags:%b want=led:%h flags:%b",
                           led, flags, e.led, e.flags);
                end
            end
        end
        prev_v = result_valid;
    end

    task automatic chk(input string tag, input int got, input int want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic press(input logic [4:0] m);
        btns = m;
        repeat (12) @(negedge clk);
        btns = 5'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic op(input logic [4:0] m, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] el, input logic [3:0] ef);
        a = av;
        b = bv;
        exp_q.push_back('{led: el, flags: ef});
        press(m);
    endtask

    initial begin
        int lat;
        rst_n    = 1'b0;
        btns     = 5'b10000;
        a        = 8'h10;
        b        = 8'h05;
        acc_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_led", int'(led), 0);
        chk("rst_flags", int'(flags), 0);
        chk("rst_valid", int'(result_valid), 0);

        // btnU held through reset release becomes one ADD after sync + debounce + FSM.
        exp_q.push_back('{led: 8'h15, flags: 4'b0000});
        rst_n = 1'b1;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (result_valid) begin
                lat = i;
                break;
            end
        end
        chk("rst_latency", lat, 8);
        @(negedge clk);
        btns = 5'b0;
        repeat (12) @(negedge clk);

        op(5'b10000, 8'h7F, 8'h01, 8'h80, 4'b1001);
        op(5'b10000, 8'hFF, 8'h01, 8'h00, 4'b0110);
        op(5'b00001, 8'h03, 8'h05, 8'hFE, 4'b1010);
        op(5'b00001, 8'h80, 8'h01, 8'h7F, 4'b0001);
        op(5'b00001, 8'h05, 8'h05, 8'h00, 4'b0100);
        op(5'b00100, 8'hFF, 8'h01, 8'h01, 4'b0000);
        op(5'b00100, 8'h01, 8'hFF, 8'h00, 4'b0100);
        op(5'b00010, 8'h00, 8'h80, 8'hE0, 4'b1000);
        op(5'b00010, 8'h00, 8'h7C, 8'h1F, 4'b0000);

        // Bouncing btnL, then a held press with a short low glitch: one XOR total.
        a = 8'h5A;
        b = 8'h0F;
        exp_q.push_back('{led: 8'h55, flags: 4'b0000});
        for (int i = 0; i < 10; i++) begin
            btns[3] = ~btns[3];
            repeat (2) @(negedge clk);
        end
        btns = 5'b01000;
        repeat (12) @(negedge clk);
        btns = 5'b00000;
        repeat (3) @(negedge clk);
        btns = 5'b01000;
        repeat (12) @(negedge clk);
        btns = 5'b00000;
        repeat (12) @(negedge clk);
        chk("bounce_drained", exp_q.size(), 0);

        op(5'b10000, 8'h00, 8'h00, 8'h00, 4'b0100);
        acc_mode = 1'b1;
        op(5'b10000, 8'h77, 8'h03, 8'h03, 4'b0000);
        op(5'b10000, 8'h77, 8'h03, 8'h06, 4'b0000);
        op(5'b10000, 8'h77, 8'h03, 8'h09, 4'b0000);
        op(5'b10001, 8'h77, 8'h03, 8'h0C, 4'b0000);

        repeat (10) @(negedge clk);
        chk("final_led", int'(led), 12);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
